// File: rtl/cu_command_arbiter_pkg.sv
// Shared types for the command arbiter slice.
//   cu_buffer_pkg : command buffer line and buffer status layouts
//   cu_pkg        : arbiter FSM encoding, default sizing and small helpers
package cu_buffer_pkg;

    typedef struct packed {
        logic        valid;
        logic [7:0]  opcode;
        logic [31:0] data;
    } CommandBufferLine;

    typedef struct packed {
        logic       full;
        logic       alfull;
        logic       empty;
        logic [4:0] level;
    } BufferStatus;

endpackage

package cu_pkg;

    localparam int NUM_REQUESTERS_DEFAULT = 4;
    localparam int CU_MAX_REQUESTERS      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } arbiter_state_type;

    // Encode a one-hot vector (up to CU_MAX_REQUESTERS bits) to its index.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < CU_MAX_REQUESTERS; i++) begin
            idx = idx | (3'(i) & {3{onehot[i]}});
        end
        return idx;
    endfunction

    // Saturating 32-bit increment.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cu_command_arbiter_round_robin_priority_select.sv
// Combinational round-robin pick: the first requester after the pointer,
// scanning upward with wrap, wins. Output is one-hot (or zero).
module round_robin_priority_select #(
    parameter int NUM_REQUESTERS = 4,
    parameter int PTR_W          = $clog2(NUM_REQUESTERS)
) (
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic [PTR_W-1:0]          pointer,
    output logic [NUM_REQUESTERS-1:0] grant
);

    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Scan from pointer+1 around to pointer, keep only the first hit.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int off = 1; off <= NUM_REQUESTERS; off++) begin
            idx_s        = PTR_W'((int'(pointer) + off) % NUM_REQUESTERS);
            grant[idx_s] = grant[idx_s] | (request[idx_s] & ~found_s);
            found_s      = found_s | request[idx_s];
        end
    end

endmodule

// File: rtl/cu_command_arbiter.sv
// Round-robin command arbiter in front of a shared command buffer port.
// grant_out is a registered one-hot pulse; the granted command appears on
// command_out one cycle later with valid set. Back-pressure comes from
// command_buffer_status.alfull and parks the FSM in STALL with a holdoff.
// Optional statistics counters: define CU_COMMAND_ARBITER_STATS_EN.
module cu_command_arbiter
    import cu_pkg::*;
    import cu_buffer_pkg::*;
#(
    parameter int NUM_REQUESTERS = NUM_REQUESTERS_DEFAULT,
    parameter int STALL_HOLDOFF  = 2
) (
    input  logic                                     clock,
    input  logic                                     rst_in,
    input  logic                                     enabled_in,
    input  logic [NUM_REQUESTERS-1:0]                request_in,
    input  CommandBufferLine [NUM_REQUESTERS-1:0]    command_in,
    input  BufferStatus                              command_buffer_status,
    output logic [NUM_REQUESTERS-1:0]                grant_out,
    output CommandBufferLine                         command_out,
    output logic                                     arbiter_busy
`ifdef CU_COMMAND_ARBITER_STATS_EN
    ,
    output logic [NUM_REQUESTERS-1:0][31:0]          grant_count_out,
    output logic [31:0]                              stall_cycles_out
`endif
);

    localparam int PTR_W = $clog2(NUM_REQUESTERS);
    localparam int HW    = $clog2(STALL_HOLDOFF + 1);
    localparam int CMD_W = $bits(CommandBufferLine);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(STALL_HOLDOFF - 1);
    localparam logic [HW-1:0]    HOLD_MAX  = HW'(STALL_HOLDOFF);
    localparam logic [PTR_W-1:0] PTR_INIT  = PTR_W'(NUM_REQUESTERS - 1);

    arbiter_state_type           state_r;
    arbiter_state_type           state_s;
    logic [PTR_W-1:0]            ptr_r;
    logic [HW-1:0]               hold_cnt_r;
    logic [NUM_REQUESTERS-1:0]   sel_s;
    logic [NUM_REQUESTERS-1:0]   grant_s;
    logic [NUM_REQUESTERS-1:0]   grant_r;
    CommandBufferLine            stage_cmd_s;
    CommandBufferLine            stage_r;
    CommandBufferLine            cmd_r;
    logic                        busy_r;
    logic                        alfull_s;
    logic                        any_req_s;

    assign alfull_s  = command_buffer_status.alfull;
    assign any_req_s = |request_in;

    round_robin_priority_select #(
        .NUM_REQUESTERS (NUM_REQUESTERS),
        .PTR_W          (PTR_W)
    ) u_rr_select (
        .request (request_in),
        .pointer (ptr_r),
        .grant   (sel_s)
    );

    // Next-state and grant decision; disable freezes the FSM and blocks grants.
    always_comb begin
        state_s = state_r;
        grant_s = '0;
        case (state_r)
            IDLE: begin
                if (!enabled_in)    state_s = IDLE;
                else if (alfull_s)  state_s = STALL;
                else if (any_req_s) state_s = GRANT;
                else                state_s = IDLE;
            end
            GRANT: begin
                if (!enabled_in)     state_s = GRANT;
                else if (alfull_s)   state_s = STALL;
                else if (!any_req_s) state_s = IDLE;
                else                 state_s = GRANT;
            end
            STALL: begin
                if (!enabled_in)                  state_s = STALL;
                else if (alfull_s)                state_s = STALL;
                else if (hold_cnt_r >= HOLD_LAST) state_s = IDLE;
                else                              state_s = STALL;
            end
            default: state_s = IDLE;
        endcase
        if (enabled_in && (state_s == GRANT)) begin
            grant_s = sel_s;
        end else begin
            grant_s = '0;
        end
    end

    // Select the granted requester's command and mark it valid.
    always_comb begin
        stage_cmd_s = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            stage_cmd_s = stage_cmd_s | (command_in[i] & {CMD_W{grant_s[i]}});
        end
        stage_cmd_s.valid = |grant_s;
    end

    // FSM state, round-robin pointer and registered outputs.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            state_r <= IDLE;
            ptr_r   <= PTR_INIT;
            grant_r <= '0;
            stage_r <= '0;
            cmd_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (|grant_s) begin
                ptr_r <= PTR_W'(onehot_to_index(8'(grant_s)));
            end
            grant_r <= grant_s;
            stage_r <= stage_cmd_s;
            cmd_r   <= stage_r;
            busy_r  <= any_req_s | (state_s != IDLE);
        end
    end

    // STALL holdoff: counts consecutive low-alfull cycles, cleared by alfull.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            hold_cnt_r <= '0;
        end else if (alfull_s || (state_r != STALL)) begin
            hold_cnt_r <= '0;
        end else if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
        end
    end

    assign grant_out    = grant_r;
    assign command_out  = cmd_r;
    assign arbiter_busy = busy_r;

`ifdef CU_COMMAND_ARBITER_STATS_EN
    logic [NUM_REQUESTERS-1:0][31:0] grant_cnt_r;
    logic [31:0]                     stall_cnt_r;

    // Saturating per-requester grant counters and STALL residency counter.
    always_ff @(posedge clock) begin
        if (rst_in) begin
            grant_cnt_r <= '0;
            stall_cnt_r <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_REQUESTERS; i++) begin
                if (grant_s[i]) begin
                    grant_cnt_r[i] <= sat_inc32(grant_cnt_r[i]);
                end
            end
            if (state_r == STALL) begin
                stall_cnt_r <= sat_inc32(stall_cnt_r);
            end
        end
    end

    assign grant_count_out  = grant_cnt_r;
    assign stall_cycles_out = stall_cnt_r;
`endif

endmodule
